// File: rtl/cnt_rr_arb8_pkg.sv
// Shared definitions for the cnt_rr_arb8 round-robin arbiter: state encoding,
// widths and the rotating-priority search.
package cnt_rr_arb8_pkg;

   localparam int unsigned ID_W     = 3;
   localparam int unsigned NREQ_MAX = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StGap  = 2'd2
   } state_e;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] id;
   } pick_t;

   // Scan ptr, ptr+1, ... wrapping at 8. Callers mask bits >= NREQ to zero, so
   // the wrap behaves as NREQ-1 -> 0.
   function automatic pick_t first_from(input logic [ID_W-1:0]     ptr,
                                        input logic [NREQ_MAX-1:0] req);
      pick_t           res;
      logic [ID_W-1:0] idx;
      res = '0;
      for (int unsigned k = 0; k < NREQ_MAX; k++) begin
         idx = ptr + ID_W'(k);
         if (!res.found && req[idx]) begin
            res.found = 1'b1;
            res.id    = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cnt_rr_arb8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface cnt_rr_arb8_if;
   import cnt_rr_arb8_pkg::*;

   logic                arb_en;
   logic [NREQ_MAX-1:0] req;
   logic [NREQ_MAX-1:0] gnt;
   logic                gnt_vld;
   logic [ID_W-1:0]     gnt_id;
   logic                busy;
   logic                tmo;

   modport master (
      output arb_en, req,
      input  gnt, gnt_vld, gnt_id, busy, tmo
   );

   modport slave (
      input  arb_en, req,
      output gnt, gnt_vld, gnt_id, busy, tmo
   );

endinterface

// File: rtl/cnt_rr_arb8_rr_ptr3.sv
// 3-bit enabled wrapping counter with synchronous load; load beats enable.
module rr_ptr3
   import cnt_rr_arb8_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            ld,
   input  logic [ID_W-1:0] ld_val,
   input  logic [ID_W-1:0] wrap_at,
   output logic [ID_W-1:0] count
);

   logic [ID_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (ld) begin
         count_d = ld_val;
      end else if (en) begin
         count_d = (count_q == wrap_at) ? '0 : count_q + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cnt_rr_arb8.sv
// Round-robin arbiter for up to 8 requesters: rotating pointer priority, grant
// held until release or MAX_HOLD timeout, then a one-cycle gap.
module cnt_rr_arb8
   import cnt_rr_arb8_pkg::*;
#(
   parameter int unsigned NREQ     = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input logic          clk,
   input logic          reset,
   cnt_rr_arb8_if.slave bus
);

   localparam logic [NREQ_MAX-1:0] ReqMask  = NREQ_MAX'((32'd1 << NREQ) - 32'd1);
   localparam logic [ID_W-1:0]     LastId   = ID_W'(NREQ - 1);
   localparam logic [7:0]          HoldLast = 8'(MAX_HOLD - 1);

   state_e              state_q, state_d;
   logic [7:0]          hold_q, hold_d;
   logic [NREQ_MAX-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                tmo_q, tmo_d;

   logic [NREQ_MAX-1:0] req_m;
   logic [ID_W-1:0]     ptr, ptr_nxt;
   pick_t               pick;
   logic                grant;

   assign req_m   = bus.req & ReqMask;
   assign pick    = first_from(ptr, req_m);
   assign grant   = (state_q == StIdle) && bus.arb_en && pick.found;
   // Winner drops to lowest priority for the next round.
   assign ptr_nxt = (pick.id == LastId) ? '0 : pick.id + ID_W'(1);

   rr_ptr3 u_ptr (
      .clk     (clk),
      .reset   (reset),
      .en      (1'b0),
      .ld      (grant),
      .ld_val  (ptr_nxt),
      .wrap_at (LastId),
      .count   (ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         hold_q  <= '0;
         gnt_q   <= '0;
         id_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d = StBusy;
               hold_d  = '0;
               gnt_d   = NREQ_MAX'(1) << pick.id;
               id_d    = pick.id;
            end
         end
         StBusy: begin
            hold_d = hold_q + 8'd1;
            // A release in the timeout cycle counts as normal, so req is tested first.
            if (!req_m[id_q] || (hold_q == HoldLast)) begin
               state_d = StGap;
               hold_d  = '0;
               gnt_d   = '0;
               id_d    = '0;
               tmo_d   = req_m[id_q];
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      bus.gnt     = gnt_q;
      bus.gnt_vld = |gnt_q;
      bus.gnt_id  = id_q;
      bus.busy    = (state_q != StIdle);
      bus.tmo     = tmo_q;
   end

endmodule

// File: tb/tb_cnt_rr_arb8.sv
// Directed bench for cnt_rr_arb8; expected grants are queued by the stimulus and
// retired by a monitor when each grant ends.
module tb_cnt_rr_arb8;
   import cnt_rr_arb8_pkg::*;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] id;
      int         len;
      logic       tmo;
      logic       gap;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic mon_en = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   cnt_rr_arb8_if bus_if ();

   cnt_rr_arb8 #(
      .NREQ     (8),
      .MAX_HOLD (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] g, input logic [2:0] id, input int len,
                       input logic tmo, input logic gap);
      exp_t e;
      e.gnt = g;
      e.id  = id;
      e.len = len;
      e.tmo = tmo;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rst, input logic en, input logic [7:0] rq, input int n);
      reset         = rst;
      bus_if.arb_en = en;
      bus_if.req    = rq;
      tick(n);
   endtask

   // Monitor: per-cycle invariants, grant tracking and scoreboard retirement.
   initial begin
      logic [7:0] cur_g;
      logic       in_g;
      logic       post;
      int         len;
      exp_t       e;
      in_g  = 1'b0;
      post  = 1'b0;
      len   = 0;
      cur_g = '0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         check("gnt_vs_id", {24'd0, bus_if.gnt},
               bus_if.gnt_vld ? (32'd1 << bus_if.gnt_id) : 32'd0);
         check("gnt_vld", {31'd0, bus_if.gnt_vld}, {31'd0, |bus_if.gnt});
         if (!bus_if.gnt_vld) check("gnt_id_idle", {29'd0, bus_if.gnt_id}, 32'd0);
         if (post) begin
            post = 1'b0;
            check("gap_one_cycle", {31'd0, bus_if.busy}, 32'd0);
         end
         if (bus_if.gnt_vld && !in_g) begin
            in_g  = 1'b1;
            cur_g = bus_if.gnt;
            len   = 1;
            check("unexpected_grant", {31'd0, exp_q.size() != 0}, 32'd1);
         end else if (bus_if.gnt_vld && in_g) begin
            len++;
            check("gnt_stable", {24'd0, bus_if.gnt}, {24'd0, cur_g});
         end else if (!bus_if.gnt_vld && in_g) begin
            in_g = 1'b0;
            if (exp_q.size() == 0) begin
               check("grant_expected", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("gnt", {24'd0, cur_g}, {24'd0, e.gnt});
               check("gnt_len", len, e.len);
               check("tmo_at_release", {31'd0, bus_if.tmo}, {31'd0, e.tmo});
               check("busy_in_gap", {31'd0, bus_if.busy}, {31'd0, e.gap});
               post = e.gap;
            end
         end else begin
            check("tmo_idle", {31'd0, bus_if.tmo}, 32'd0);
         end
      end
   end

   // Grant ids are checked through gnt (one-hot) plus the gnt_vs_id invariant.
   initial begin
      drive(1'b1, 1'b1, 8'hFF, 2);
      mon_en = 1'b1;
      check("rst_gnt", {24'd0, bus_if.gnt}, 32'd0);
      check("rst_vld", {31'd0, bus_if.gnt_vld}, 32'd0);
      check("rst_id", {29'd0, bus_if.gnt_id}, 32'd0);
      check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst_tmo", {31'd0, bus_if.tmo}, 32'd0);

      // From ptr=0: id0 then id3.
      push(8'h01, 3'd0, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h09, 1);
      check("first_grant_latency", {24'd0, bus_if.gnt}, 32'h01);
      push(8'h08, 3'd3, 2, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h08, 4);
      drive(1'b0, 1'b1, 8'h00, 3);

      // ptr=4: grant id6 (ptr->7), then 7, then wrap to 0.
      push(8'h40, 3'd6, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h40, 1);
      push(8'h80, 3'd7, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h81, 3);
      push(8'h01, 3'd0, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h01, 3);
      drive(1'b0, 1'b1, 8'h00, 2);

      // Timeout after 16 cycles, then re-grant of id2 once ptr comes round.
      push(8'h04, 3'd2, 16, 1'b1, 1'b1);
      push(8'h04, 3'd2, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h04, 19);
      drive(1'b0, 1'b1, 8'h00, 2);

      // req[5] drops exactly when hold_cnt reaches MAX_HOLD-1: no tmo.
      push(8'h20, 3'd5, 16, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h20, 16);
      drive(1'b0, 1'b1, 8'h00, 3);

      // arb_en low mid-grant keeps it; reset cuts it with no gap.
      push(8'h02, 3'd1, 4, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h02, 1);
      drive(1'b0, 1'b0, 8'h02, 3);
      drive(1'b1, 1'b0, 8'h02, 1);
      check("reset_cuts_gnt", {24'd0, bus_if.gnt}, 32'd0);
      check("reset_clears_busy", {31'd0, bus_if.busy}, 32'd0);

      // ptr back at 0 so id1 wins over id3.
      push(8'h02, 3'd1, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'h0A, 1);
      drive(1'b0, 1'b1, 8'h00, 3);

      // arb_en low in IDLE blocks new grants.
      drive(1'b0, 1'b0, 8'hFF, 3);
      check("no_grant_when_disabled", {31'd0, bus_if.gnt_vld}, 32'd0);
      push(8'h04, 3'd2, 1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 8'hFF, 1);
      drive(1'b0, 1'b1, 8'h00, 4);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
